// File: rtl/mem_stage_pkg.sv
// Shared widths, load-mode encodings, MEM stage state encodings and the captured-entry payload.
package mem_stage_pkg;

  localparam int unsigned SINGLE_WORD = 32;
  localparam int unsigned GPR_NUM     = 5;
  localparam int unsigned LOAD_MODE   = 3;

  typedef enum logic [LOAD_MODE-1:0] {
    LM_LW  = 3'd0,
    LM_LB  = 3'd1,
    LM_LBU = 3'd2,
    LM_LH  = 3'd3,
    LM_LHU = 3'd4
  } load_mode_e;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT    = 2'd1,
    S_READY   = 2'd2,
    S_DISCARD = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [GPR_NUM-1:0]     write_num;
    logic [SINGLE_WORD-1:0] vaddr;
    logic [SINGLE_WORD-1:0] reg_data;
    load_mode_e             load_mode;
  } mem_entry_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and payload from the delayed-execution stage into the MEM stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                   REEXE_valid_w_i;
  logic                   MEM_allowin_w_o;
  logic [GPR_NUM-1:0]     REEXE_writeNum_i;
  logic [SINGLE_WORD-1:0] REEXE_VAddr_i;
  logic [SINGLE_WORD-1:0] REEXE_regData_i;
  logic                   REEXE_isLoad_i;
  logic [LOAD_MODE-1:0]   REEXE_loadMode_i;

  modport master (
    output REEXE_valid_w_i, REEXE_writeNum_i, REEXE_VAddr_i,
           REEXE_regData_i, REEXE_isLoad_i, REEXE_loadMode_i,
    input  MEM_allowin_w_o
  );

  modport slave (
    input  REEXE_valid_w_i, REEXE_writeNum_i, REEXE_VAddr_i,
           REEXE_regData_i, REEXE_isLoad_i, REEXE_loadMode_i,
    output MEM_allowin_w_o
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half-word of a cache read and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [SINGLE_WORD-1:0] rdata_i,
  input  logic [1:0]             addr_i,
  input  load_mode_e             loadMode_i,
  output logic [SINGLE_WORD-1:0] aligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    aligned_o = rdata_i;
    unique case (loadMode_i)
      LM_LB:   aligned_o = {{24{byte_sel[7]}}, byte_sel};
      LM_LBU:  aligned_o = {24'd0, byte_sel};
      LM_LH:   aligned_o = {{16{half_sel[15]}}, half_sel};
      LM_LHU:  aligned_o = {16'd0, half_sel};
      default: aligned_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data, aligns it and hands the result to WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  mem_stage_if.slave             reexe,
  input  logic                   dc_data_ok_w_i,
  input  logic [SINGLE_WORD-1:0] dc_rdata_w_i,
  input  logic                   WB_allowin_w_i,
  input  logic                   flush_w_i,
  output logic                   MEM_valid_w_o,
  output logic                   MEM_forwardMode_w_o,
  output logic [GPR_NUM-1:0]     MEM_writeNum_w_o,
  output logic [GPR_NUM-1:0]     MEM_writeNum_o,
  output logic [SINGLE_WORD-1:0] MEM_VAddr_o,
  output logic [SINGLE_WORD-1:0] MEM_regData_o
);

  mem_state_e             state_q, state_d;
  mem_entry_t             entry_q, entry_d;
  logic                   allowin;
  logic                   capture;
  logic [SINGLE_WORD-1:0] aligned;

  load_align u_load_align (
    .rdata_i    (dc_rdata_w_i),
    .addr_i     (entry_q.vaddr[1:0]),
    .loadMode_i (entry_q.load_mode),
    .aligned_o  (aligned)
  );

  assign allowin = (state_q == S_EMPTY) || ((state_q == S_READY) && WB_allowin_w_i);
  assign capture = allowin && reexe.REEXE_valid_w_i && !flush_w_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  // Next state and stage registers; flush outranks capture and always clears the destination.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    unique case (state_q)
      S_EMPTY: begin
        if (capture) state_d = reexe.REEXE_isLoad_i ? S_WAIT : S_READY;
      end
      S_WAIT: begin
        if (flush_w_i) begin
          state_d = dc_data_ok_w_i ? S_EMPTY : S_DISCARD;
        end else if (dc_data_ok_w_i) begin
          state_d          = S_READY;
          entry_d.reg_data = aligned;
        end
      end
      S_READY: begin
        if (flush_w_i) begin
          state_d = S_EMPTY;
        end else if (WB_allowin_w_i) begin
          if (capture) state_d = reexe.REEXE_isLoad_i ? S_WAIT : S_READY;
          else         state_d = S_EMPTY;
        end
      end
      S_DISCARD: begin
        if (dc_data_ok_w_i) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase

    if (capture) begin
      entry_d.write_num = reexe.REEXE_writeNum_i;
      entry_d.vaddr     = reexe.REEXE_VAddr_i;
      entry_d.reg_data  = reexe.REEXE_regData_i;
      entry_d.load_mode = load_mode_e'(reexe.REEXE_loadMode_i);
    end
    if (flush_w_i) entry_d.write_num = '0;
  end

  assign reexe.MEM_allowin_w_o = allowin;
  assign MEM_valid_w_o         = (state_q == S_READY) && WB_allowin_w_i && !flush_w_i;
  assign MEM_forwardMode_w_o   = (state_q == S_READY);
  assign MEM_writeNum_w_o      = ((state_q == S_WAIT) || (state_q == S_READY)) ? entry_q.write_num : '0;
  assign MEM_writeNum_o        = entry_q.write_num;
  assign MEM_VAddr_o           = entry_q.vaddr;
  assign MEM_regData_o         = entry_q.reg_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load alignment, backpressure, flush and reset cases.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        dc_data_ok_w_i;
  logic [31:0] dc_rdata_w_i;
  logic        WB_allowin_w_i;
  logic        flush_w_i;
  logic        MEM_valid_w_o;
  logic        MEM_forwardMode_w_o;
  logic [4:0]  MEM_writeNum_w_o;
  logic [4:0]  MEM_writeNum_o;
  logic [31:0] MEM_VAddr_o;
  logic [31:0] MEM_regData_o;

  int checks   = 0;
  int failures = 0;

  mem_stage_if rx ();

  mem_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .reexe               (rx),
    .dc_data_ok_w_i      (dc_data_ok_w_i),
    .dc_rdata_w_i        (dc_rdata_w_i),
    .WB_allowin_w_i      (WB_allowin_w_i),
    .flush_w_i           (flush_w_i),
    .MEM_valid_w_o       (MEM_valid_w_o),
    .MEM_forwardMode_w_o (MEM_forwardMode_w_o),
    .MEM_writeNum_w_o    (MEM_writeNum_w_o),
    .MEM_writeNum_o      (MEM_writeNum_o),
    .MEM_VAddr_o         (MEM_VAddr_o),
    .MEM_regData_o       (MEM_regData_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wn, input logic [31:0] va,
                       input logic [31:0] rd, input logic ld, input logic [2:0] lm);
    rx.REEXE_valid_w_i  = v;
    rx.REEXE_writeNum_i = wn;
    rx.REEXE_VAddr_i    = va;
    rx.REEXE_regData_i  = rd;
    rx.REEXE_isLoad_i   = ld;
    rx.REEXE_loadMode_i = lm;
  endtask

  // Capture a load, hold off the cache for `waits` cycles, then check the aligned result.
  task automatic do_load(input string tag, input logic [2:0] lm, input logic [31:0] va,
                         input logic [31:0] rdata, input int waits, input logic [31:0] exp);
    drive(1'b1, 5'd6, va, 32'h0, 1'b1, lm);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    #1;
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_wait_fwd"}, 32'(MEM_forwardMode_w_o), 32'd0);
      chk({tag, "_wait_allowin"}, 32'(rx.MEM_allowin_w_o), 32'd0);
      step();
    end
    chk({tag, "_wait_wn_w"}, 32'(MEM_writeNum_w_o), 32'd6);
    dc_data_ok_w_i = 1'b1;
    dc_rdata_w_i   = rdata;
    #1;
    chk({tag, "_okcyc_valid"}, 32'(MEM_valid_w_o), 32'd0);
    step();
    dc_data_ok_w_i = 1'b0;
    dc_rdata_w_i   = 32'hDEADBEEF;
    #1;
    chk({tag, "_fwd"}, 32'(MEM_forwardMode_w_o), 32'd1);
    chk({tag, "_data"}, MEM_regData_o, exp);
    chk({tag, "_valid"}, 32'(MEM_valid_w_o), 32'd1);
    step();
  endtask

  initial begin
    rst = 1'b0;
    dc_data_ok_w_i = 1'b0;
    dc_rdata_w_i   = 32'h0;
    WB_allowin_w_i = 1'b1;
    flush_w_i      = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    step();
    step();
    chk("rst_valid", 32'(MEM_valid_w_o), 32'd0);
    chk("rst_fwd", 32'(MEM_forwardMode_w_o), 32'd0);
    chk("rst_wn_w", 32'(MEM_writeNum_w_o), 32'd0);
    chk("rst_wn", 32'(MEM_writeNum_o), 32'd0);
    chk("rst_vaddr", MEM_VAddr_o, 32'd0);
    chk("rst_data", MEM_regData_o, 32'd0);
    chk("rst_allowin", 32'(rx.MEM_allowin_w_o), 32'd1);
    rst = 1'b1;
    step();

    // Non-load pass-through
    drive(1'b1, 5'd5, 32'h0000_0100, 32'h1234_5678, 1'b0, 3'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    #1;
    chk("nl_valid", 32'(MEM_valid_w_o), 32'd1);
    chk("nl_fwd", 32'(MEM_forwardMode_w_o), 32'd1);
    chk("nl_data", MEM_regData_o, 32'h1234_5678);
    chk("nl_wn_w", 32'(MEM_writeNum_w_o), 32'd5);
    chk("nl_vaddr", MEM_VAddr_o, 32'h0000_0100);
    step();
    chk("nl_drain_fwd", 32'(MEM_forwardMode_w_o), 32'd0);
    chk("nl_drain_wn_w", 32'(MEM_writeNum_w_o), 32'd0);
    chk("nl_drain_allowin", 32'(rx.MEM_allowin_w_o), 32'd1);

    // Load alignment
    do_load("lb3",  3'd1, 32'h0000_2003, 32'h80FF_1234, 3, 32'hFFFF_FF80);
    do_load("lbu3", 3'd2, 32'h0000_2003, 32'h80FF_1234, 3, 32'h0000_0080);
    do_load("lb1",  3'd1, 32'h0000_2001, 32'h80FF_1234, 0, 32'h0000_0012);
    do_load("lh2",  3'd3, 32'h0000_2002, 32'h80FF_1234, 1, 32'hFFFF_80FF);
    do_load("lhu2", 3'd4, 32'h0000_2002, 32'h80FF_1234, 1, 32'h0000_80FF);
    do_load("lh0",  3'd3, 32'h0000_2000, 32'h80FF_1234, 0, 32'h0000_1234);
    do_load("lw",   3'd0, 32'h0000_2000, 32'h80FF_1234, 2, 32'h80FF_1234);

    // Backpressure with a waiting follower, then back-to-back capture on release
    WB_allowin_w_i = 1'b0;
    drive(1'b1, 5'd7, 32'h0000_0300, 32'hA5A5_A5A5, 1'b0, 3'd0);
    step();
    drive(1'b1, 5'd9, 32'h0000_0400, 32'h0BAD_F00D, 1'b0, 3'd0);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_fwd", 32'(MEM_forwardMode_w_o), 32'd1);
      chk("bp_valid", 32'(MEM_valid_w_o), 32'd0);
      chk("bp_allowin", 32'(rx.MEM_allowin_w_o), 32'd0);
      chk("bp_data", MEM_regData_o, 32'hA5A5_A5A5);
      chk("bp_wn_w", 32'(MEM_writeNum_w_o), 32'd7);
      step();
    end
    WB_allowin_w_i = 1'b1;
    #1;
    chk("bp_rel_valid", 32'(MEM_valid_w_o), 32'd1);
    chk("bp_rel_allowin", 32'(rx.MEM_allowin_w_o), 32'd1);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    #1;
    chk("b2b_data", MEM_regData_o, 32'h0BAD_F00D);
    chk("b2b_wn_w", 32'(MEM_writeNum_w_o), 32'd9);
    chk("b2b_valid", 32'(MEM_valid_w_o), 32'd1);
    step();
    chk("b2b_empty_fwd", 32'(MEM_forwardMode_w_o), 32'd0);

    // Flush in WAIT, response two cycles later is dropped
    drive(1'b1, 5'd3, 32'h0000_5000, 32'h0000_CAFE, 1'b1, 3'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    flush_w_i = 1'b1;
    #1;
    chk("fw_flush_valid", 32'(MEM_valid_w_o), 32'd0);
    step();
    flush_w_i = 1'b0;
    #1;
    chk("disc1_allowin", 32'(rx.MEM_allowin_w_o), 32'd0);
    chk("disc1_wn_w", 32'(MEM_writeNum_w_o), 32'd0);
    chk("disc1_wn", 32'(MEM_writeNum_o), 32'd0);
    chk("disc1_fwd", 32'(MEM_forwardMode_w_o), 32'd0);
    step();
    dc_data_ok_w_i = 1'b1;
    dc_rdata_w_i   = 32'h1111_1111;
    #1;
    chk("disc2_allowin", 32'(rx.MEM_allowin_w_o), 32'd0);
    chk("disc2_valid", 32'(MEM_valid_w_o), 32'd0);
    step();
    dc_data_ok_w_i = 1'b0;
    #1;
    chk("disc_end_allowin", 32'(rx.MEM_allowin_w_o), 32'd1);
    chk("disc_end_fwd", 32'(MEM_forwardMode_w_o), 32'd0);
    chk("disc_end_valid", 32'(MEM_valid_w_o), 32'd0);
    chk("disc_end_data", MEM_regData_o, 32'h0000_CAFE);

    // Flush in READY under backpressure
    WB_allowin_w_i = 1'b0;
    drive(1'b1, 5'd4, 32'h0000_6000, 32'h0000_0044, 1'b0, 3'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    WB_allowin_w_i = 1'b1;
    flush_w_i = 1'b1;
    #1;
    chk("fr_valid", 32'(MEM_valid_w_o), 32'd0);
    step();
    flush_w_i = 1'b0;
    #1;
    chk("fr_fwd", 32'(MEM_forwardMode_w_o), 32'd0);
    chk("fr_wn", 32'(MEM_writeNum_o), 32'd0);
    chk("fr_allowin", 32'(rx.MEM_allowin_w_o), 32'd1);

    // Flush beats capture in EMPTY
    drive(1'b1, 5'd8, 32'h0000_7000, 32'h0000_0088, 1'b0, 3'd0);
    flush_w_i = 1'b1;
    step();
    flush_w_i = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    #1;
    chk("fc_fwd", 32'(MEM_forwardMode_w_o), 32'd0);
    chk("fc_wn_w", 32'(MEM_writeNum_w_o), 32'd0);

    // Reset during WAIT
    drive(1'b1, 5'd12, 32'h0000_8004, 32'h0000_0099, 1'b1, 3'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    step();
    chk("rw_pre_wn_w", 32'(MEM_writeNum_w_o), 32'd12);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rw_allowin", 32'(rx.MEM_allowin_w_o), 32'd1);
    chk("rw_fwd", 32'(MEM_forwardMode_w_o), 32'd0);
    chk("rw_valid", 32'(MEM_valid_w_o), 32'd0);
    chk("rw_wn_w", 32'(MEM_writeNum_w_o), 32'd0);
    chk("rw_wn", 32'(MEM_writeNum_o), 32'd0);
    chk("rw_vaddr", MEM_VAddr_o, 32'd0);
    chk("rw_data", MEM_regData_o, 32'd0);
    step();
    chk("rw_next_allowin", 32'(rx.MEM_allowin_w_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
